pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_channel.sv | 99 +++++++++
 rtl/pwm_multi.sv | 100 ++++++++++
 tb/tb_pwm_multi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// pwm_pkg: register map, CTRL bit positions and mode encoding shared by pwm_multi and pwm_channel.
// Rev 1.0
package pwm_pkg;

  // Byte offsets inside one 16-byte channel block
  localparam logic [3:0] OFF_PULSE_WIDTH = 4'h0;
  localparam logic [3:0] OFF_MAX_COUNTER = 4'h4;
  localparam logic [3:0] OFF_CTRL        = 4'h8;
  localparam logic [3:0] OFF_COUNTER     = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_INV  = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_W    = 3;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// pwm_channel: one PWM channel with shadow/active width and max, up/down counter and output flop.
// Rev 1.0
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CtrSize = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pw_we,
  input  logic               max_we,
  input  logic               ctrl_we,
  input  logic [CtrSize-1:0] pw_wdata,
  input  logic [CtrSize-1:0] max_wdata,
  input  logic [CTRL_W-1:0]  ctrl_wdata,
  output logic [CtrSize-1:0] shadow_pw,
  output logic [CtrSize-1:0] shadow_max,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [CtrSize-1:0] counter,
  output logic               pwm
);

  logic [CtrSize-1:0] active_pw;
  logic [CtrSize-1:0] active_max;
  logic               dir_down;
  logic [CtrSize-1:0] cnt_nxt;
  logic               dir_nxt;
  logic               boundary;
  logic               enable;
  logic               invert;
  pwm_mode_e          mode;

  assign enable = ctrl[CTRL_EN];
  assign invert = ctrl[CTRL_INV];
  assign mode   = pwm_mode_e'(ctrl[CTRL_MODE]);

  always_comb begin
    cnt_nxt = counter;
    dir_nxt = 1'b0;
    if (mode == MODE_EDGE) begin
      cnt_nxt = (counter >= active_max) ? '0 : counter + CtrSize'(1);
    end else if (!dir_down) begin
      if (counter < active_max) begin
        cnt_nxt = counter + CtrSize'(1);
      end else if (active_max == '0) begin
        cnt_nxt = '0;
      end else begin
        // Turn around at the top; with max = 1 this lands straight on 0 going up again
        cnt_nxt = counter - CtrSize'(1);
        dir_nxt = (counter - CtrSize'(1)) != '0;
      end
    end else begin
      if (counter > CtrSize'(1)) begin
        cnt_nxt = counter - CtrSize'(1);
        dir_nxt = 1'b1;
      end else begin
        cnt_nxt = '0;
      end
    end
  end

  // Both modes re-enter 0 exactly once per period, so that is the reload point
  assign boundary = (cnt_nxt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_pw  <= '0;
      shadow_max <= '0;
      ctrl       <= '0;
      active_pw  <= '0;
      active_max <= '0;
      counter    <= '0;
      dir_down   <= 1'b0;
      pwm        <= 1'b0;
    end else begin
      if (pw_we)   shadow_pw  <= pw_wdata;
      if (max_we)  shadow_max <= max_wdata;
      if (ctrl_we) ctrl       <= ctrl_wdata;
      if (!enable) begin
        counter    <= '0;
        dir_down   <= 1'b0;
        active_pw  <= shadow_pw;
        active_max <= shadow_max;
        pwm        <= invert;
      end else begin
        counter  <= cnt_nxt;
        dir_down <= dir_nxt;
        if (boundary) begin
          active_pw  <= shadow_pw;
          active_max <= shadow_max;
        end
        pwm <= (counter < active_pw) ^ invert;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// pwm_multi: bus-mapped bank of independent PWM channels; decodes device bus, muxes reads.
// Rev 1.0
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NumChannels = 12,
  parameter int CtrSize     = 8,
  parameter int BusWidth    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   device_req_i,
  input  logic [BusWidth-1:0]    device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [BusWidth-1:0]    device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [BusWidth-1:0]    device_rdata_o,
  output logic [NumChannels-1:0] pwm_o
);

  logic [5:0]          ch_idx;
  logic [3:0]          reg_off;
  logic [31:0]         wdata32;
  logic                wr_req;
  logic [BusWidth-1:0] rd_val;
  logic                unused_bus;

  logic [CtrSize-1:0] sh_pw  [NumChannels];
  logic [CtrSize-1:0] sh_max [NumChannels];
  logic [CTRL_W-1:0]  ctrl   [NumChannels];
  logic [CtrSize-1:0] cnt    [NumChannels];

  assign ch_idx     = device_addr_i[9:4];
  assign reg_off    = {device_addr_i[3:2], 2'b00};
  assign wdata32    = device_wdata_i[31:0];
  assign wr_req     = device_req_i & device_we_i;
  assign unused_bus = ^{device_addr_i, device_wdata_i};

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    logic        sel;
    logic [31:0] pw_merged;
    logic [31:0] max_merged;
    logic [31:0] ctrl_merged;
    logic        unused_merge;

    assign sel         = wr_req & (ch_idx == 6'(i));
    assign pw_merged   = be_merge(32'(sh_pw[i]), wdata32, device_be_i);
    assign max_merged  = be_merge(32'(sh_max[i]), wdata32, device_be_i);
    assign ctrl_merged = be_merge(32'(ctrl[i]), wdata32, device_be_i);
    assign unused_merge = ^{pw_merged, max_merged, ctrl_merged};

    pwm_channel #(
      .CtrSize(CtrSize)
    ) u_channel (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .pw_we     (sel & (reg_off == OFF_PULSE_WIDTH)),
      .max_we    (sel & (reg_off == OFF_MAX_COUNTER)),
      .ctrl_we   (sel & (reg_off == OFF_CTRL)),
      .pw_wdata  (pw_merged[CtrSize-1:0]),
      .max_wdata (max_merged[CtrSize-1:0]),
      .ctrl_wdata(ctrl_merged[CTRL_W-1:0]),
      .shadow_pw (sh_pw[i]),
      .shadow_max(sh_max[i]),
      .ctrl      (ctrl[i]),
      .counter   (cnt[i]),
      .pwm       (pwm_o[i])
    );
  end

  // Channel indices past NumChannels never match, so they read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (ch_idx == 6'(i)) begin
        case (reg_off)
          OFF_PULSE_WIDTH: rd_val = BusWidth'(sh_pw[i]);
          OFF_MAX_COUNTER: rd_val = BusWidth'(sh_max[i]);
          OFF_CTRL:        rd_val = BusWidth'(ctrl[i]);
          OFF_COUNTER:     rd_val = BusWidth'(cnt[i]);
          default:         rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      if (device_req_i) device_rdata_o <= device_we_i ? '0 : rd_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// tb_pwm_multi: randomized scoreboard bench; a phase-based period model predicts pwm_o and read data.
// Rev 1.0
module tb_pwm_multi;

  localparam int NCH = 12;
  localparam int CW  = 8;
  localparam int BW  = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic           we = 1'b0;
  logic [BW-1:0]  addr = '0;
  logic [BW-1:0]  wdata = '0;
  logic [3:0]     be = '0;
  logic           rvalid;
  logic [BW-1:0]  rdata;
  logic [NCH-1:0] pwm;

  always #5 clk = ~clk;

  pwm_multi #(.NumChannels(NCH), .CtrSize(CW), .BusWidth(BW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .pwm_o          (pwm)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: each enabled channel walks a phase index through its period
  int sh_pw[NCH], sh_max[NCH], m_ctrl[NCH], a_pw[NCH], a_max[NCH], ph[NCH];
  logic [NCH-1:0] exp_pwm = '0;
  logic [31:0]    rq[$];
  bit             rst_seen = 1'b0;

  function automatic int cval(input int ch);
    if (((m_ctrl[ch] >> 2) & 1) == 0) return ph[ch];
    return (ph[ch] <= a_max[ch]) ? ph[ch] : 2 * a_max[ch] - ph[ch];
  endfunction

  function automatic int period(input int ch);
    if (((m_ctrl[ch] >> 2) & 1) == 0) return a_max[ch] + 1;
    return (a_max[ch] == 0) ? 1 : 2 * a_max[ch];
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    int ch, r;
    ch = int'((a >> 4) & 32'h3F);
    r  = int'((a >> 2) & 32'h3);
    if (ch >= NCH) return 0;
    case (r)
      0: return sh_pw[ch];
      1: return sh_max[ch];
      2: return m_ctrl[ch];
      default: return cval(ch);
    endcase
  endfunction

  function automatic int merge(input int old_v, input logic [31:0] d, input logic [3:0] b, input int keep);
    int res;
    res = old_v;
    for (int l = 0; l < 4; l++)
      if (b[l]) res = (res & ~(255 << (8 * l))) | (int'(d) & (255 << (8 * l)));
    return res & keep;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        sh_pw[c] = 0; sh_max[c] = 0; m_ctrl[c] = 0; a_pw[c] = 0; a_max[c] = 0; ph[c] = 0;
      end
      exp_pwm  = '0;
      rq.delete();
      rst_seen = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit en, inv, raw;
        en  = (m_ctrl[c] & 1) != 0;
        inv = ((m_ctrl[c] >> 1) & 1) != 0;
        raw = cval(c) < a_pw[c];
        exp_pwm[c] = en ? (raw ^ inv) : inv;
      end
      if (req) rq.push_back(we ? 32'h0 : mread(addr));
      for (int c = 0; c < NCH; c++) begin
        bit reload;
        reload = 1'b1;
        if ((m_ctrl[c] & 1) != 0) begin
          ph[c]++;
          if (ph[c] >= period(c)) ph[c] = 0;
          else reload = 1'b0;
        end else begin
          ph[c] = 0;
        end
        if (reload) begin
          a_pw[c]  = sh_pw[c];
          a_max[c] = sh_max[c];
        end
      end
      if (req && we) begin
        int ch, r;
        ch = int'((addr >> 4) & 32'h3F);
        r  = int'((addr >> 2) & 32'h3);
        if (ch < NCH) begin
          case (r)
            0: sh_pw[ch]  = merge(sh_pw[ch], wdata, be, 255);
            1: sh_max[ch] = merge(sh_max[ch], wdata, be, 255);
            2: m_ctrl[ch] = merge(m_ctrl[ch], wdata, be, 7);
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: compares outputs every cycle and pops a response whenever one is due
  always @(negedge clk) begin
    logic [31:0] e;
    chk("pwm_o", 32'(pwm), 32'(exp_pwm));
    chk("rvalid", 32'(rvalid), 32'(rq.size() != 0));
    if (rq.size() != 0) begin
      e = rq.pop_front();
      if (rvalid) chk("rdata", rdata, e);
    end
    if (rst_seen) begin
      chk("rdata_after_reset", rdata, 32'h0);
      rst_seen = 1'b0;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; wdata = $urandom; be = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0; we = 1'b0;
    end
  endtask

  task automatic capture(input int ch, input int n, output logic [63:0] pat);
    pat = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      pat[i] = pwm[ch];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 1'b0; we = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("pwm_after_reset", 32'(pwm), 32'h0);
  endtask

  initial begin
    logic [63:0] pat;
    int n;

    idle(3);
    rst_n = 1'b1;
    idle(1);

    // ch0 edge-aligned PW=3 MAX=7: 3 high per 8
    wr(32'h00, 32'd3); wr(32'h04, 32'd7); wr(32'h08, 32'h1);
    idle(3);
    capture(0, 16, pat);
    chk("ch0_edge_duty", $countones(pat[15:0]), 32'd6);
    chk("ch0_edge_period", 32'(pat[7:0]), 32'(pat[15:8]));

    // ch1 center-aligned PW=2 MAX=4: period 8
    wr(32'h10, 32'd2); wr(32'h14, 32'd4); wr(32'h18, 32'h5);
    idle(3);
    n = 0;
    for (int p = 0; p < 8; p++) if (((p <= 4) ? p : 8 - p) < 2) n++;
    capture(1, 16, pat);
    chk("ch1_center_duty", $countones(pat[15:0]), 32'(2 * n));
    chk("ch1_center_period", 32'(pat[7:0]), 32'(pat[15:8]));

    // Live counter read, unmapped and out-of-range channel accesses
    rd(32'h0C); rd(32'h3F0); wr(32'hD0, 32'h55); rd(32'hD0); rd(32'h1C); idle(2);

    // Mid-period width change only affects the following period
    idle(3);
    wr(32'h00, 32'd6);
    idle(17);
    capture(0, 16, pat);
    chk("ch0_new_width", $countones(pat[15:0]), 32'd12);
    rd(32'h00);

    // ch2 inverted, PW=0 -> constantly high; oversized width truncates
    wr(32'h28, 32'h3);
    idle(3);
    capture(2, 10, pat);
    chk("ch2_const_high", $countones(pat[9:0]), 32'd10);
    wr(32'h20, 32'h1FF); rd(32'h20);
    wr(32'h24, 32'h0000_AB05, 4'b0010); rd(32'h24);
    wr(32'h24, 32'h1234_5603, 4'b0001); rd(32'h24); rd(32'h28);
    idle(4);

    // Reset mid-period, then every register reads back zero
    do_reset();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) rd(32'((c << 4) | (r << 2)));
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel, ch, r;
      logic [31:0] d;
      sel = int'($urandom_range(0, 99));
      if (sel < 25) begin
        idle(int'($urandom_range(1, 3)));
      end else if (sel == 99) begin
        do_reset();
      end else begin
        ch = ($urandom_range(0, 15) < 13) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
        r  = int'($urandom_range(0, 3));
        if (sel < 55) begin
          rd(32'((ch << 4) | (r << 2)));
        end else begin
          case (r)
            0: d = ($urandom_range(0, 9) == 0) ? 32'h1FF : 32'($urandom_range(0, 11));
            1: d = 32'($urandom_range(0, 9));
            2: d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7));
            default: d = $urandom;
          endcase
          // Keep mode fixed while a channel runs so the phase model stays meaningful
          if (r == 2 && ch < NCH && (m_ctrl[ch] & 1) != 0)
            d[2] = ((m_ctrl[ch] >> 2) & 1) != 0;
          wr(32'((ch << 4) | (r << 2)), d, 4'($urandom_range(0, 15)));
        end
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
